ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter; the send half of the keyboard link whose receive half is the ps2 block.

---
 rtl/ps2_host_tx_pkg.sv | 23 ++
 rtl/ps2_line_sync.sv | 27 ++
 rtl/ps2_host_tx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Imported by ps2_host_tx and ps2_line_sync.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    BITS      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge strobe.
// Shared with the PS/2 receive block.
module ps2_line_sync
  import ps2_host_tx_pkg::*;
(
  input  logic clk28,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic [2:0] sync_r;

  // Two synchroniser stages plus one delayed copy; idle-high after reset so no false edge.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      sync_r <= 3'b111;
    end else begin
      sync_r <= {sync_r[1:0], line_in};
    end
  end

  assign line_sync = sync_r[1];
  assign line_fall = sync_r[2] & ~sync_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional retry on failure is enabled by defining PS2_TX_RETRY_EN.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 28_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_US = 15000,
  parameter int MAX_RETRY  = 2
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  // 64-bit arithmetic: the products overflow 32 bits at the default clock.
  localparam longint INH_CYC = longint'(INHIBIT_US) * longint'(CLK_FREQ) / 64'sd1_000_000;
  localparam longint TO_CYC  = longint'(TIMEOUT_US) * longint'(CLK_FREQ) / 64'sd1_000_000;
  localparam int INH_W = $clog2(INH_CYC + 64'sd1);
  localparam int TO_W  = $clog2(TO_CYC + 64'sd1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 64'sd1);
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TO_CYC);
  localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};

  if (MAX_RETRY > 3) begin : g_retry_range
    $error("MAX_RETRY does not fit the 2-bit retry counter");
  end

  ps2tx_state_t     state_r, state_nxt;
  logic [7:0]       data_r, data_nxt;
  logic             parity_r, parity_nxt;
  logic [3:0]       bit_cnt_r, bit_cnt_nxt;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_nxt;
  logic [TO_W-1:0]  to_cnt_r;
  logic             to_clr_s, to_expired_s, fail_s;
  logic             clk_oe_r, clk_oe_nxt, dat_oe_r, dat_oe_nxt;
  logic             done_nxt, error_nxt;
  logic             tx_ready_r, tx_done_r, tx_error_r, rx_inhibit_r;
  logic             clk_sync_s, clk_fall_s, dat_sync_s, dat_fall_unused_s;
`ifdef PS2_TX_RETRY_EN
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
  logic [1:0] retry_cnt_r, retry_nxt;
`endif

  ps2_line_sync u_clk_sync (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync_s),
    .line_fall (clk_fall_s)
  );

  ps2_line_sync u_dat_sync (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .line_in   (ps2_dat_in),
    .line_sync (dat_sync_s),
    .line_fall (dat_fall_unused_s)
  );

  assign to_expired_s = (to_cnt_r >= TO_LIM);

  // Next-state, line drive and pulse decisions.
  always_comb begin
    state_nxt   = state_r;
    data_nxt    = data_r;
    parity_nxt  = parity_r;
    bit_cnt_nxt = bit_cnt_r;
    inh_cnt_nxt = inh_cnt_r;
    clk_oe_nxt  = clk_oe_r;
    dat_oe_nxt  = dat_oe_r;
    to_clr_s    = 1'b0;
    fail_s      = 1'b0;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_nxt   = retry_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        if (tx_valid && tx_ready_r) begin
          state_nxt   = INHIBIT;
          data_nxt    = tx_data;
          parity_nxt  = odd_parity(tx_data);
          bit_cnt_nxt = 4'd0;
          inh_cnt_nxt = {INH_W{1'b0}};
          clk_oe_nxt  = 1'b1;
`ifdef PS2_TX_RETRY_EN
          retry_nxt   = 2'd0;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      INHIBIT: begin
        clk_oe_nxt = 1'b1;
        if (inh_cnt_r == INH_LAST) begin
          state_nxt  = REQ;
          dat_oe_nxt = 1'b1;
        end else begin
          inh_cnt_nxt = inh_cnt_r + INH_W'(1);
          dat_oe_nxt  = 1'b0;
        end
      end
      REQ: begin
        state_nxt  = BITS;
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b1;
        to_clr_s   = 1'b1;
      end
      BITS: begin
        if (to_expired_s) begin
          fail_s = 1'b1;
        end else if (clk_fall_s) begin
          bit_cnt_nxt = bit_cnt_r + 4'd1;
          case (bit_cnt_r)
            4'd8:    dat_oe_nxt = ~parity_r;
            4'd9: begin
              dat_oe_nxt = 1'b0;
              state_nxt  = ACK;
            end
            default: dat_oe_nxt = ~data_r[bit_cnt_r[2:0]];
          endcase
        end else begin
          state_nxt = BITS;
        end
      end
      ACK: begin
        if (to_expired_s) begin
          fail_s = 1'b1;
        end else if (clk_fall_s) begin
          if (!dat_sync_s) begin
            state_nxt = WAIT_IDLE;
          end else begin
            fail_s = 1'b1;
          end
        end else begin
          state_nxt = ACK;
        end
      end
      WAIT_IDLE: begin
        if (to_expired_s) begin
          fail_s = 1'b1;
        end else if (clk_sync_s && dat_sync_s) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
      end
    endcase

    if (fail_s) begin
      clk_oe_nxt = 1'b0;
      dat_oe_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt_r < RETRY_LIM) begin
        retry_nxt   = retry_cnt_r + 2'd1;
        state_nxt   = INHIBIT;
        clk_oe_nxt  = 1'b1;
        inh_cnt_nxt = {INH_W{1'b0}};
        bit_cnt_nxt = 4'd0;
      end else begin
        state_nxt = IDLE;
        error_nxt = 1'b1;
      end
`else
      state_nxt = IDLE;
      error_nxt = 1'b1;
`endif
    end else begin
      error_nxt = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      data_r       <= 8'h00;
      parity_r     <= 1'b0;
      bit_cnt_r    <= 4'd0;
      inh_cnt_r    <= {INH_W{1'b0}};
      clk_oe_r     <= 1'b0;
      dat_oe_r     <= 1'b0;
      tx_ready_r   <= 1'b1;
      tx_done_r    <= 1'b0;
      tx_error_r   <= 1'b0;
      rx_inhibit_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      data_r       <= data_nxt;
      parity_r     <= parity_nxt;
      bit_cnt_r    <= bit_cnt_nxt;
      inh_cnt_r    <= inh_cnt_nxt;
      clk_oe_r     <= clk_oe_nxt;
      dat_oe_r     <= dat_oe_nxt;
      tx_ready_r   <= (state_nxt == IDLE);
      tx_done_r    <= done_nxt;
      tx_error_r   <= error_nxt;
      rx_inhibit_r <= (state_nxt != IDLE);
    end
  end

  // Whole-frame timeout measured from clock release; saturates instead of wrapping.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (to_clr_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Retry count for the byte currently in flight.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      retry_cnt_r <= 2'd0;
    end else begin
      retry_cnt_r <= retry_nxt;
    end
  end
`endif

  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;
  assign tx_ready   = tx_ready_r;
  assign tx_done    = tx_done_r;
  assign tx_error   = tx_error_r;
  assign rx_inhibit = rx_inhibit_r;

endmodule
